// File: rtl/delay_serial.sv
// ============================================================================
// Module      : delay_serial
// Description : Column-to-pixel serialiser. Accepts one HEIGHT_NB-pixel column
//               per handshake and emits its lanes one pixel per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_serial #(
    parameter int HEIGHT_NB = 3,
    parameter int IMG_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CNT_WIDTH-1:0]           cfg_rows,
    input  logic                           cfg_set,
    input  logic [IMG_WIDTH*HEIGHT_NB-1:0] up_data,
    input  logic                           up_val,
    output logic                           up_rdy,
    output logic [IMG_WIDTH-1:0]           dn_data,
    output logic                           dn_val,
    input  logic                           dn_rdy,
    output logic                           dn_last
);

    localparam logic [CNT_WIDTH-1:0] C_HEIGHT = CNT_WIDTH'(HEIGHT_NB);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [IMG_WIDTH*HEIGHT_NB-1:0] r_shift_data;
    logic [IMG_WIDTH*HEIGHT_NB-1:0] r_hold_data;
    logic [IMG_WIDTH*HEIGHT_NB-1:0] w_load_data;
    logic                           r_hold_full;
    logic                           r_up_rdy;
    logic [CNT_WIDTH-1:0]           r_cnt;
    logic [CNT_WIDTH-1:0]           r_rows;
    logic [CNT_WIDTH-1:0]           r_col_rows;
    logic [CNT_WIDTH-1:0]           w_cfg_rows;
    logic                           w_shifting;
    logic                           w_last;
    logic                           w_up_fire;
    logic                           w_dn_fire;
    logic                           w_col_done;
    logic                           w_shift_free;
    logic                           w_load;
    logic                           w_to_hold;
    logic                           w_hold_full_next;

    assign w_shifting   = (r_state == S_SHIFT);
    assign w_last       = w_shifting && (r_cnt == r_col_rows - CNT_WIDTH'(1));
    assign w_up_fire    = up_val & r_up_rdy;
    assign w_dn_fire    = w_shifting & dn_rdy;
    assign w_col_done   = w_dn_fire & w_last;
    assign w_shift_free = ~w_shifting | w_col_done;
    // Hold always has priority over a fresh column so ordering is preserved.
    assign w_load       = w_shift_free & (r_hold_full | w_up_fire);
    assign w_load_data  = r_hold_full ? r_hold_data : up_data;
    assign w_to_hold    = w_up_fire & ~(w_shift_free & ~r_hold_full);
    assign w_hold_full_next = w_shift_free ? (r_hold_full & w_up_fire)
                                           : (r_hold_full | w_up_fire);
    assign w_cfg_rows   = ((cfg_rows == '0) || (cfg_rows > C_HEIGHT)) ? C_HEIGHT : cfg_rows;

    assign up_rdy = r_up_rdy;
    assign dn_val = w_shifting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        dn_data      = '0;
        dn_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int h = 0; h < HEIGHT_NB; h++) begin
                    if (r_cnt == CNT_WIDTH'(h)) begin
                        dn_data = r_shift_data[h*IMG_WIDTH +: IMG_WIDTH];
                    end
                end
                dn_last = w_last;
                if (w_col_done && !w_load) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_data <= '0;
            r_hold_data  <= '0;
            r_hold_full  <= 1'b0;
            r_up_rdy     <= 1'b0;
            r_cnt        <= '0;
            r_rows       <= C_HEIGHT;
            r_col_rows   <= C_HEIGHT;
        end else begin
            r_up_rdy    <= ~w_hold_full_next;
            r_hold_full <= w_hold_full_next;
            if (cfg_set) begin
                r_rows <= w_cfg_rows;
            end
            if (w_to_hold) begin
                r_hold_data <= up_data;
            end
            // The row count is frozen per column at load time.
            if (w_load) begin
                r_shift_data <= w_load_data;
                r_col_rows   <= r_rows;
                r_cnt        <= '0;
            end else if (w_col_done) begin
                r_cnt <= '0;
            end else if (w_dn_fire) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire
